hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter SHADOW_CYCLES, default 4, bubbles inserted after a control-flow instruction leaves IF/ID; legal 1..7.
REQ-002 Parameter LOAD_STALLS, default 1, bubbles inserted for a load-use hazard; legal 1..3.
REQ-003 Parameter IR_WIDTH, default 16, instruction register width; opcode in [IR_WIDTH-1:IR_WIDTH-4].
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flow  input  1  pipeline advance enable for IF/ID to ID/EX; state holds when 0.
REQ-007 if_id_ir  input  IR_WIDTH  instruction in decode.
REQ-008 id_ex_ir  input  IR_WIDTH  instruction in execute.
REQ-009 branch_enable  input  1  BR condition result for the branch being resolved.
REQ-010 gen_bubble  output  1  inject NOP into ID/EX and hold IF/ID this cycle.
REQ-011 squash_ID  output  1  convert current IF/ID instruction into a NOP.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Source decode: sr1=[8:6] for ADD, AND, NOT, SHF, LDB, LDR, LDI, STB, STR, STI, JMP, JSR with bit11=0; sr2=[2:0] for ADD/AND with bit5=0; store source=[11:9] for STB, STR, STI.
REQ-014 Load-use hazard: id_ex_ir opcode in {LDB, LDR, LDI} and its [11:9] equals any needed source of if_id_ir.
REQ-015 Control-flow: if_id_ir nonzero and opcode JMP, JSR or TRAP, or BR with nzp!=000; BR nzp=000 and all-zero IR are NOPs.
REQ-016 States: IDLE, LDSTALL, SHADOW, RESOLVE; 3-bit down-counter cnt; saved opcode register cf_op; registered taken bit.
REQ-017 IDLE, load-use hazard: gen_bubble=1 combinationally; if LOAD_STALLS>1 go LDSTALL with cnt=LOAD_STALLS-1 on flow, else remain IDLE.
REQ-018 LDSTALL: gen_bubble=1; cnt decrements on flow; at cnt=1 with flow go IDLE.
REQ-019 IDLE, control-flow and no load-use hazard: gen_bubble=0, on flow save opcode to cf_op, cnt=SHADOW_CYCLES, go SHADOW.
REQ-020 Load-use hazard takes priority over control-flow detection in the same cycle; control-flow detects after stall ends.
REQ-021 SHADOW: gen_bubble=1; cnt decrements on flow; at cnt=1 with flow go RESOLVE.
REQ-022 taken register loads branch_enable on every flow cycle.
REQ-023 RESOLVE: gen_bubble=0; squash_ID=1 if cf_op!=BR, or cf_op=BR and taken=1; go IDLE on flow.
REQ-024 flow=0: state, cnt, cf_op, taken hold; outputs remain the combinational function of held state and inputs.
REQ-025 squash_ID is 0 in every state other than RESOLVE; gen_bubble and squash_ID are never both 1.

Reset
REQ-026 reset asserted: state=IDLE, cnt=0, cf_op=0, taken=0 immediately, regardless of clk.
REQ-027 During and after reset, until hazard inputs arise: gen_bubble=0, squash_ID=0, busy=0; reset mid-SHADOW abandons the shadow without squash.

Configuration
REQ-028 Macro HAZARD_PERF_EN defined: adds outputs bubble_count [31:0] (+1 per flow cycle with gen_bubble=1) and squash_count [15:0] (+1 per flow cycle with squash_ID=1), both saturating, reset to 0.
REQ-029 Macro undefined: neither port nor counters exist; all other behaviour identical.

Verification
REQ-030 id_ex_ir=LDR R1,R2,#0, if_id_ir=ADD R3,R1,R4, flow=1, LOAD_STALLS=1 -> gen_bubble=1 one cycle, busy=0, then 0.
REQ-031 Same with LOAD_STALLS=3 -> gen_bubble=1 for 3 consecutive flow cycles, busy=1 for last 2.
REQ-032 if_id_ir=BRz, SHADOW_CYCLES=4, branch_enable=1 in last SHADOW cycle -> 4 bubbles, then squash_ID=1 one cycle, IDLE.
REQ-033 if_id_ir=BRn, branch_enable=0 -> 4 bubbles, squash_ID=0 in RESOLVE.
REQ-034 JMP in SHADOW with flow=0 for 3 cycles mid-count -> cnt held, total still 4 bubbles then squash_ID=1.
REQ-035 reset pulsed in SHADOW with cnt=2 -> state IDLE, outputs 0 same cycle; with HAZARD_PERF_EN, bubble_count=0.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls and control-flow shadow bubbles with branch squash.
// Optional HAZARD_PERF_EN adds saturating bubble/squash event counters.
module hazard_unit #(
  parameter int SHADOW_CYCLES = 4,
  parameter int LOAD_STALLS   = 1,
  parameter int IR_WIDTH      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flow,
  input  logic [IR_WIDTH-1:0] if_id_ir,
  input  logic [IR_WIDTH-1:0] id_ex_ir,
  input  logic                branch_enable,
  output logic                gen_bubble,
  output logic                squash_ID,
  output logic                busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         bubble_count,
  output logic [15:0]         squash_count
`endif
);

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LDB = 4'b0010,
                         OP_STB = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                         OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                         OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_SHF = 4'b1101, OP_TRAP = 4'b1111;

  localparam logic [2:0] SHADOW_CNT = 3'(SHADOW_CYCLES);
  localparam logic [2:0] LDSTALL_CNT = 3'(LOAD_STALLS - 1);
  localparam bit         LS_MULTI = (LOAD_STALLS > 1);

  typedef enum logic [1:0] {IDLE, LDSTALL, SHADOW, RESOLVE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] cf_op_q, cf_op_d;
  logic       taken_q, taken_d;

  logic [3:0] id_op, ex_op;
  logic [2:0] ex_dr;
  logic       needs_sr1, needs_sr2, needs_st, ex_load, load_use, ctrl_flow;
  logic       unused_ir;

  assign id_op = if_id_ir[IR_WIDTH-1 -: 4];
  assign ex_op = id_ex_ir[IR_WIDTH-1 -: 4];
  assign ex_dr = id_ex_ir[11:9];
  assign unused_ir = ^{if_id_ir, id_ex_ir};

  assign needs_sr1 = (id_op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LDB, OP_LDR,
                                    OP_LDI, OP_STB, OP_STR, OP_STI, OP_JMP})
                   || (id_op == OP_JSR && !if_id_ir[11]);
  assign needs_sr2 = (id_op == OP_ADD || id_op == OP_AND) && !if_id_ir[5];
  assign needs_st  = id_op inside {OP_STB, OP_STR, OP_STI};
  assign ex_load   = ex_op inside {OP_LDB, OP_LDR, OP_LDI};

  assign load_use = ex_load && ((needs_sr1 && if_id_ir[8:6] == ex_dr)
                             || (needs_sr2 && if_id_ir[2:0] == ex_dr)
                             || (needs_st  && if_id_ir[11:9] == ex_dr));

  // BR with nzp=000 and the all-zero word are NOPs, not control flow.
  assign ctrl_flow = (|if_id_ir)
                  && ((id_op inside {OP_JMP, OP_JSR, OP_TRAP})
                      || (id_op == OP_BR && (|if_id_ir[11:9])));

  assign busy    = (state_q != IDLE);
  assign taken_d = flow ? branch_enable : taken_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cf_op_d    = cf_op_q;
    gen_bubble = 1'b0;
    squash_ID  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_use) begin
          gen_bubble = 1'b1;
          if (LS_MULTI && flow) begin
            state_d = LDSTALL;
            cnt_d   = LDSTALL_CNT;
          end
        end else if (ctrl_flow && flow) begin
          state_d = SHADOW;
          cnt_d   = SHADOW_CNT;
          cf_op_d = id_op;
        end
      end
      LDSTALL: begin
        gen_bubble = 1'b1;
        if (flow) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = IDLE;
        end
      end
      SHADOW: begin
        gen_bubble = 1'b1;
        if (flow) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        squash_ID = (cf_op_q != OP_BR) || taken_q;
        if (flow) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      cf_op_q <= 4'd0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cf_op_q <= cf_op_d;
      taken_q <= taken_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= 32'd0;
      squash_count <= 16'd0;
    end else if (flow) begin
      if (gen_bubble && bubble_count != 32'hFFFF_FFFF) bubble_count <= bubble_count + 32'd1;
      if (squash_ID && squash_count != 16'hFFFF) squash_count <= squash_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (LOAD_STALLS=1 and 3) share stimulus;
// the driver queues expected {gen_bubble,squash_ID,busy} per cycle, a monitor pops and compares.
module tb_hazard_unit;

  localparam logic [15:0] LDR_R1   = 16'h6280; // LDR R1,R2,#0
  localparam logic [15:0] LDR_R4   = 16'h6880; // LDR R4,R2,#0
  localparam logic [15:0] ADD_REG  = 16'h1644; // ADD R3,R1,R4
  localparam logic [15:0] ADD_IMM  = 16'h1664; // ADD R3,R1,#4
  localparam logic [15:0] STR_R1   = 16'h7280; // STR R1,R2,#0
  localparam logic [15:0] BRZ      = 16'h0402;
  localparam logic [15:0] BRN      = 16'h0802;
  localparam logic [15:0] BR_NONE  = 16'h0005;
  localparam logic [15:0] JMP_R2   = 16'hC080;
  localparam logic [15:0] TRAP_25  = 16'hF025;
  localparam logic [15:0] JSRR_R1  = 16'h4040;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flow = 1'b0;
  logic [15:0] if_id_ir = '0;
  logic [15:0] id_ex_ir = '0;
  logic        branch_enable = 1'b0;
  logic        gb1, sq1, bz1, gb3, sq3, bz3;
`ifdef HAZARD_PERF_EN
  logic [31:0] bc1, bc3;
  logic [15:0] sc1, sc3;
`endif

  always #5 clk = ~clk;

  hazard_unit #(.SHADOW_CYCLES(4), .LOAD_STALLS(1), .IR_WIDTH(16)) u_dut1 (
    .clk(clk), .reset(reset), .flow(flow), .if_id_ir(if_id_ir), .id_ex_ir(id_ex_ir),
    .branch_enable(branch_enable), .gen_bubble(gb1), .squash_ID(sq1), .busy(bz1)
`ifdef HAZARD_PERF_EN
    , .bubble_count(bc1), .squash_count(sc1)
`endif
  );

  hazard_unit #(.SHADOW_CYCLES(4), .LOAD_STALLS(3), .IR_WIDTH(16)) u_dut3 (
    .clk(clk), .reset(reset), .flow(flow), .if_id_ir(if_id_ir), .id_ex_ir(id_ex_ir),
    .branch_enable(branch_enable), .gen_bubble(gb3), .squash_ID(sq3), .busy(bz3)
`ifdef HAZARD_PERF_EN
    , .bubble_count(bc3), .squash_count(sc3)
`endif
  );

  typedef struct {
    logic [2:0] e1;
    logic [2:0] e3;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string nm, input logic f, input logic [15:0] ii,
                      input logic [15:0] ei, input logic be, input logic r,
                      input logic [2:0] x1, input logic [2:0] x3);
    exp_t e;
    @(posedge clk);
    #1;
    flow = f;
    if_id_ir = ii;
    id_ex_ir = ei;
    branch_enable = be;
    reset = r;
    e.e1 = x1;
    e.e3 = x3;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are combinational every cycle, so one entry is consumed per negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if ({gb1, sq1, bz1} !== mon_e.e1) begin
          errors++;
          $display("FAIL %s ls1 {bubble,squash,busy} got=%b exp=%b", mon_e.name, {gb1, sq1, bz1}, mon_e.e1);
        end
        checks++;
        if ({gb3, sq3, bz3} !== mon_e.e3) begin
          errors++;
          $display("FAIL %s ls3 {bubble,squash,busy} got=%b exp=%b", mon_e.name, {gb3, sq3, bz3}, mon_e.e3);
        end
      end
    end
  end

  initial begin
    step("rst0",  1'b1, '0, '0, 1'b0, 1'b1, 3'b000, 3'b000);
    step("rst1",  1'b1, '0, '0, 1'b0, 1'b1, 3'b000, 3'b000);
    step("idle",  1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b000);

    // Load-use, register operand
    step("lu_c1", 1'b1, ADD_REG, LDR_R1, 1'b0, 1'b0, 3'b100, 3'b100);
    step("lu_c2", 1'b1, ADD_REG, '0,     1'b0, 1'b0, 3'b000, 3'b101);
    step("lu_c3", 1'b1, ADD_REG, '0,     1'b0, 1'b0, 3'b000, 3'b101);
    step("lu_c4", 1'b1, ADD_REG, '0,     1'b0, 1'b0, 3'b000, 3'b000);

    // Immediate ADD: field [2:0] matches the load target but is not a source
    step("imm_nohz", 1'b1, ADD_IMM, LDR_R4, 1'b0, 1'b0, 3'b000, 3'b000);

    // Store data source hazard, first with flow held low
    step("st_hold", 1'b0, STR_R1, LDR_R1, 1'b0, 1'b0, 3'b100, 3'b100);
    step("st_flow", 1'b1, STR_R1, LDR_R1, 1'b0, 1'b0, 3'b100, 3'b100);
    step("st_s2",   1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b101);
    step("st_s3",   1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b101);
    step("st_end",  1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b000);

    // BR with nzp=000 is a NOP
    step("brnop_id",  1'b1, BR_NONE, '0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("brnop_nxt", 1'b1, '0,      '0, 1'b0, 1'b0, 3'b000, 3'b000);

    // BRz taken
    step("brz_id",  1'b1, BRZ, '0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("brz_sh1", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("brz_sh2", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("brz_sh3", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("brz_sh4", 1'b1, '0,  '0, 1'b1, 1'b0, 3'b101, 3'b101);
    step("brz_res", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b011, 3'b011);
    step("brz_idl", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b000, 3'b000);

    // BRn not taken
    step("brn_id",  1'b1, BRN, '0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("brn_sh1", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("brn_sh2", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("brn_sh3", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("brn_sh4", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("brn_res", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b001, 3'b001);
    step("brn_idl", 1'b1, '0,  '0, 1'b0, 1'b0, 3'b000, 3'b000);

    // JMP with a 3-cycle flow stall mid-shadow
    step("jmp_id",  1'b1, JMP_R2, '0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("jmp_sh1", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("jmp_sh2", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("jmp_hl1", 1'b0, '0, '0, 1'b1, 1'b0, 3'b101, 3'b101);
    step("jmp_hl2", 1'b0, '0, '0, 1'b1, 1'b0, 3'b101, 3'b101);
    step("jmp_hl3", 1'b0, '0, '0, 1'b1, 1'b0, 3'b101, 3'b101);
    step("jmp_sh3", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("jmp_sh4", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("jmp_rh",  1'b0, '0, '0, 1'b0, 1'b0, 3'b011, 3'b011);
    step("jmp_res", 1'b1, '0, '0, 1'b0, 1'b0, 3'b011, 3'b011);
    step("jmp_idl", 1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b000);

    // Reset mid-shadow at cnt=2, asserted between clock edges
    step("trp_id",  1'b1, TRAP_25, '0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("trp_sh1", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("trp_sh2", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("trp_rst", 1'b1, '0, '0, 1'b0, 1'b1, 3'b000, 3'b000);
`ifdef HAZARD_PERF_EN
    #2;
    checks++;
    if (bc1 !== 32'd0 || bc3 !== 32'd0) begin
      errors++;
      $display("FAIL perf_rst bubble_count got=%0d/%0d exp=0", bc1, bc3);
    end
`endif
    step("trp_rel", 1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b000);
    step("trp_idl", 1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b000);

    // Load-use wins over control flow; JSRR detected once the stall clears
    step("pri_g1", 1'b1, JSRR_R1, LDR_R1, 1'b0, 1'b0, 3'b100, 3'b100);
    step("pri_g2", 1'b1, JSRR_R1, '0,     1'b0, 1'b0, 3'b000, 3'b101);
    step("pri_g3", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b101);
    step("pri_g4", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b000);
    step("pri_g5", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b000);
    step("pri_g6", 1'b1, '0, '0, 1'b0, 1'b0, 3'b101, 3'b000);
    step("pri_g7", 1'b1, '0, '0, 1'b0, 1'b0, 3'b011, 3'b000);
    step("pri_g8", 1'b1, '0, '0, 1'b0, 1'b0, 3'b000, 3'b000);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue_left got=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
